clk_div_multi: RTL and testbench

//  Multi-channel programmable clock divider, CLK100MHZ domain. Per channel it produces
//  a one-cycle tick_out enable and a square-wave-like clk_out level; both are flops.

---
 rtl/clk_div_multi.sv | 138 +++++++++++++
 tb/tb_clk_div_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   Multi-channel programmable clock divider in the CLK100MHZ domain. Each
//   channel produces a one-cycle tick_out enable and a clk_out level; both are
//   flops. Divisors are reloaded at run time through a single pending slot
//   (valid/ready) and take effect only at a period boundary, so a channel never
//   emits a runt period.
//
// Ports
//   CLK100MHZ   in   system clock
//   reset       in   synchronous, active-high
//   ch_en       in   [NUM_CH]        per-channel run enable
//   cfg_valid   in                   divisor update request
//   cfg_ready   out                  update accepted on cfg_valid & cfg_ready
//   cfg_ch      in   [CH_W]          target channel
//   cfg_div     in   [CNT_W]         new divisor (0 is treated as 1)
//   tick_out    out  [NUM_CH]        one-cycle pulse per divided period
//   clk_out     out  [NUM_CH]        divided level, high floor(D/2) cycles
//   active_div  out  [NUM_CH*CNT_W]  divisor in use, ch i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module clk_div_multi #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      CLK100MHZ,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [CH_W-1:0]           cfg_ch,
    input  logic [CNT_W-1:0]          cfg_div,
    output logic [NUM_CH-1:0]         tick_out,
    output logic [NUM_CH-1:0]         clk_out,
    output logic [NUM_CH*CNT_W-1:0]   active_div
);

    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
    logic [CNT_W-1:0] div_q [NUM_CH];
    logic [CNT_W-1:0] div_d [NUM_CH];
    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] wrap, apply;
    logic [NUM_CH-1:0] tick_d, clk_d;

    logic              pend_v_q, pend_v_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [CNT_W-1:0]  pend_div_q, pend_div_d;
    logic              cfg_ready_q;
    logic              xfer;

    assign cfg_ready = cfg_ready_q;
    assign xfer      = cfg_valid & cfg_ready_q;

    always_comb begin
        run_d      = '0;
        wrap       = '0;
        apply      = '0;
        tick_d     = '0;
        clk_d      = '0;
        pend_v_d   = pend_v_q;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;

        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            wrap[i]  = run_q[i] & ch_en[i] & (cnt_q[i] == div_q[i] - CNT_W'(1));
            // A pending divisor may land whenever the target is at a boundary:
            // wrapping back to 0, or (re)starting from the idle state.
            apply[i] = pend_v_q && (int'(pend_ch_q) == i)
                       && (wrap[i] || !run_q[i] || !ch_en[i]);
            div_d[i] = apply[i] ? pend_div_q : div_q[i];

            if (!ch_en[i]) begin
                run_d[i] = 1'b0;
                cnt_d[i] = '0;
            end else if (!run_q[i]) begin
                run_d[i] = 1'b1;
                cnt_d[i] = '0;
            end else begin
                run_d[i] = 1'b1;
                cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
            end

            // Outputs are computed from next-state values so the period that
            // starts with a freshly applied divisor is already shaped by it.
            tick_d[i] = run_d[i] && (cnt_d[i] == '0);
            clk_d[i]  = run_d[i] && (cnt_d[i] < (div_d[i] >> 1));
        end

        if (|apply) begin
            pend_v_d = 1'b0;
        end

        // xfer requires cfg_ready, i.e. an empty slot, so it never collides
        // with an apply. Out-of-range channels complete the handshake but are
        // discarded.
        if (xfer) begin
            pend_v_d   = (int'(cfg_ch) < NUM_CH);
            pend_ch_d  = cfg_ch;
            pend_div_d = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= CNT_W'(DEFAULT_DIV);
            end
            run_q       <= '0;
            tick_out    <= '0;
            clk_out     <= '0;
            pend_v_q    <= 1'b0;
            pend_ch_q   <= '0;
            pend_div_q  <= '0;
            cfg_ready_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                div_q[i] <= div_d[i];
            end
            run_q       <= run_d;
            tick_out    <= tick_d;
            clk_out     <= clk_d;
            pend_v_q    <= pend_v_d;
            pend_ch_q   <= pend_ch_d;
            pend_div_q  <= pend_div_d;
            cfg_ready_q <= ~pend_v_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_active
        assign active_div[g*CNT_W +: CNT_W] = div_q[g];
    end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ch_en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [0:0]  cfg_ch;
    logic [7:0]  cfg_div;
    logic [1:0]  tick_out;
    logic [1:0]  clk_out;
    logic [15:0] active_div;

    logic [2:0]  ch_en3;
    logic        cfg_valid3;
    logic        cfg_ready3;
    logic [1:0]  cfg_ch3;
    logic [7:0]  cfg_div3;
    logic [2:0]  tick_out3;
    logic [2:0]  clk_out3;
    logic [23:0] active_div3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_div_multi u_dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .ch_en     (ch_en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .tick_out  (tick_out),
        .clk_out   (clk_out),
        .active_div(active_div)
    );

    // Three channels give a 2-bit cfg_ch, so an out-of-range channel (3) is expressible.
    clk_div_multi #(.NUM_CH(3)) u_dut3 (
        .CLK100MHZ (clk),
        .reset     (reset),
        .ch_en     (ch_en3),
        .cfg_valid (cfg_valid3),
        .cfg_ready (cfg_ready3),
        .cfg_ch    (cfg_ch3),
        .cfg_div   (cfg_div3),
        .tick_out  (tick_out3),
        .clk_out   (clk_out3),
        .active_div(active_div3)
    );

    typedef struct packed {
        logic [1:0]  en;
        logic        v;
        logic        ch;
        logic [7:0]  div;
        logic [1:0]  tick;
        logic [1:0]  clk;
        logic        rdy;
        logic [15:0] ad;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int high;
        bit seen;

        // inputs {en, v, ch, div} then expected {tick, clk, rdy, active_div}
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 1'b1, 16'h0404}); // 0 first cycle
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b11, 1'b1, 16'h0404});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 16'h0404});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 16'h0404});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 1'b1, 16'h0404}); // 4
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b11, 1'b1, 16'h0404}); // cnt=1
        tbl.push_back({2'b11, 1'b1, 1'b0, 8'd5, 2'b00, 2'b00, 1'b0, 16'h0404}); // 6 ch0 <- 5
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b0, 16'h0404});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b11, 1'b1, 16'h0405}); // 8 applied
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b11, 1'b1, 16'h0405});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 16'h0405});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 16'h0405});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b10, 1'b1, 16'h0405}); // 12
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b01, 2'b11, 1'b1, 16'h0405});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b01, 1'b1, 16'h0405});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b00, 1'b1, 16'h0405});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b10, 1'b1, 16'h0405}); // 16
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b00, 2'b10, 1'b1, 16'h0405});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b01, 2'b01, 1'b1, 16'h0405});
        tbl.push_back({2'b11, 1'b1, 1'b1, 8'd1, 2'b00, 2'b01, 1'b0, 16'h0405}); // 19 ch1 <- 1
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 16'h0105}); // 20 applied
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 16'h0105});
        tbl.push_back({2'b11, 1'b1, 1'b1, 8'd0, 2'b10, 2'b00, 1'b0, 16'h0105}); // 22 ch1 <- 0
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b01, 1'b1, 16'h0105});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b01, 1'b1, 16'h0105}); // ch0 cnt=1
        tbl.push_back({2'b10, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 16'h0105}); // 25 ch0 off
        tbl.push_back({2'b10, 1'b1, 1'b0, 8'd3, 2'b10, 2'b00, 1'b0, 16'h0105}); // ch0 <- 3
        tbl.push_back({2'b10, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 16'h0103}); // idle apply
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b01, 1'b1, 16'h0103}); // 28 re-enable
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 16'h0103});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b10, 2'b00, 1'b1, 16'h0103});
        tbl.push_back({2'b11, 1'b0, 1'b0, 8'd0, 2'b11, 2'b01, 1'b1, 16'h0103}); // 31

        reset      = 1'b1;
        ch_en      = 2'b00;
        cfg_valid  = 1'b0;
        cfg_ch     = 1'b0;
        cfg_div    = 8'd0;
        ch_en3     = 3'b111;
        cfg_valid3 = 1'b0;
        cfg_ch3    = 2'd0;
        cfg_div3   = 8'd0;
        repeat (3) step();

        chk("rst_tick", 32'(tick_out), 32'h0);
        chk("rst_clk", 32'(clk_out), 32'h0);
        chk("rst_ready", 32'(cfg_ready), 32'h0);
        chk("rst_div", 32'(active_div), 32'h0404);

        reset = 1'b0;
        foreach (tbl[i]) begin
            ch_en     = tbl[i].en;
            cfg_valid = tbl[i].v;
            cfg_ch    = tbl[i].ch;
            cfg_div   = tbl[i].div;
            step();
            chk($sformatf("v%0d_tick", i), 32'(tick_out), 32'(tbl[i].tick));
            chk($sformatf("v%0d_clk", i), 32'(clk_out), 32'(tbl[i].clk));
            chk($sformatf("v%0d_ready", i), 32'(cfg_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_div", i), 32'(active_div), 32'(tbl[i].ad));
        end
        cfg_valid = 1'b0;

        // Reset mid-period with an update pending: all back to default, update lost.
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd7;
        step();
        chk("pend_ready", 32'(cfg_ready), 32'h0);
        cfg_valid = 1'b0;
        reset     = 1'b1;
        step();
        chk("mid_rst_tick", 32'(tick_out), 32'h0);
        chk("mid_rst_clk", 32'(clk_out), 32'h0);
        chk("mid_rst_ready", 32'(cfg_ready), 32'h0);
        chk("mid_rst_div", 32'(active_div), 32'h0404);
        step();
        reset = 1'b0;
        step();
        chk("post_rst_tick", 32'(tick_out), 32'h3);
        chk("post_rst_clk", 32'(clk_out), 32'h3);
        chk("post_rst_ready", 32'(cfg_ready), 32'h1);
        repeat (4) step();
        chk("post_rst_tick4", 32'(tick_out), 32'h3);
        chk("post_rst_div4", 32'(active_div), 32'h0404);

        // Largest divisor on ch1: 255-cycle period, 127 cycles high.
        cfg_valid = 1'b1;
        cfg_ch    = 1'b1;
        cfg_div   = 8'd255;
        step();
        cfg_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            seen = tick_out[1];
        end
        chk("max_apply_seen", 32'(seen), 32'h1);
        chk("max_div", 32'(active_div), 32'hFF04);
        n = 0;
        high = 0;
        seen = 1'b0;
        while (!seen && n < 600) begin
            high += int'(clk_out[1]);
            step();
            n++;
            seen = tick_out[1];
        end
        chk("max_period", 32'(n), 32'd255);
        chk("max_high", 32'(high), 32'd127);

        // Out-of-range channel: handshake completes, nothing changes.
        chk("oor_ready_pre", 32'(cfg_ready3), 32'h1);
        cfg_valid3 = 1'b1;
        cfg_ch3    = 2'd3;
        cfg_div3   = 8'd9;
        step();
        cfg_valid3 = 1'b0;
        chk("oor_ready", 32'(cfg_ready3), 32'h1);
        repeat (6) step();
        chk("oor_ready_later", 32'(cfg_ready3), 32'h1);
        chk("oor_div", 32'(active_div3), 32'h040404);

        // Same instance, legal channel 2: accepted, then applied within a period.
        cfg_valid3 = 1'b1;
        cfg_ch3    = 2'd2;
        step();
        cfg_valid3 = 1'b0;
        chk("ch2_ready_low", 32'(cfg_ready3), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = cfg_ready3;
        end
        chk("ch2_ready_back", 32'(seen), 32'h1);
        chk("ch2_div", 32'(active_div3), 32'h090404);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
